// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver with F0/E0 prefix stripping and a per-key held/press table.
// Ports: clk, rst_n (async active-low); ps2_clk, ps2_data (raw pins);
//        key_held/key_press (per tracked key); scan_code/scan_valid/scan_break/scan_ext (last decoded byte);
//        frame_err (pulse on bad start/parity/stop or in-frame timeout).
// Optional feature: define PS2_EXT_EN to treat E0 as an extended prefix reported on scan_ext.
module ps2_key_decoder #(
    parameter int                    NUM_KEYS       = 4,
    parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = {8'h23, 8'h1B, 8'h1C, 8'h1D},
    parameter int                    FILTER_LEN     = 4,
    parameter int                    TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [7:0]          scan_code,
    output logic                scan_valid,
    output logic                scan_break,
    output logic                scan_ext,
    output logic                frame_err
);
    localparam int         TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] FL_M1 = 4'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_M1 = TW'(TIMEOUT_CYCLES - 1);
`ifdef PS2_EXT_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    logic [1:0]    clk_sync, data_sync;
    logic          clk_filt;
    logic [3:0]    filt_cnt;
    logic          filt_flip, strobe, data_bit;
    state_t        state, state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_ok;
    logic [TW-1:0] tmo_cnt;
    logic          frame_bad, byte_ok, tmo_hit, deliver;
    logic          brk_pend;
    logic [NUM_KEYS-1:0] match;
    // Pins idle high, so synchronisers and the filtered clock reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_filt  <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_flip) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 4'd1;
            end
        end
    end
    // The FILTER_LEN-th consecutive differing sample flips the filtered level.
    assign filt_flip = (clk_sync[1] != clk_filt) && (filt_cnt == FL_M1);
    assign strobe    = filt_flip && clk_filt;
    assign data_bit  = data_sync[1];
    always_comb begin
        state_d   = state;
        frame_bad = 1'b0;
        byte_ok   = 1'b0;
        tmo_hit   = 1'b0;
        if (strobe) begin
            unique case (state)
                IDLE:   if (data_bit) frame_bad = 1'b1; else state_d = DATA;
                DATA:   if (bit_cnt == 3'd7) state_d = PARITY;
                PARITY: state_d = STOP;
                STOP: begin
                    state_d   = IDLE;
                    byte_ok   = data_bit && par_ok;
                    frame_bad = !(data_bit && par_ok);
                end
            endcase
        end else if (state != IDLE && tmo_cnt == TO_M1) begin
            state_d   = IDLE;
            frame_bad = 1'b1;
            tmo_hit   = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par_ok  <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_d;
            tmo_cnt <= (state == IDLE || strobe) ? '0 : tmo_cnt + 1'b1;
            if (strobe && state == IDLE)
                bit_cnt <= '0;
            if (strobe && state == DATA) begin
                shift   <= {data_bit, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (strobe && state == PARITY)
                par_ok <= ^{data_bit, shift};
        end
    end
    // Prefix bytes only arm flags; every other good byte is published with the flags and clears them.
    assign deliver = byte_ok && shift != 8'hF0 && !(EXT_EN && shift == 8'hE0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_code  <= '0;
            scan_valid <= 1'b0;
            scan_break <= 1'b0;
            frame_err  <= 1'b0;
            brk_pend   <= 1'b0;
        end else begin
            scan_valid <= deliver;
            frame_err  <= frame_bad;
            if (tmo_hit) begin
                brk_pend <= 1'b0;
            end else if (byte_ok && shift == 8'hF0) begin
                brk_pend <= 1'b1;
            end else if (deliver) begin
                scan_code  <= shift;
                scan_break <= brk_pend;
                brk_pend   <= 1'b0;
            end
        end
    end
`ifdef PS2_EXT_EN
    logic ext_pend;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_pend <= 1'b0;
            scan_ext <= 1'b0;
        end else if (tmo_hit) begin
            ext_pend <= 1'b0;
        end else if (byte_ok && shift == 8'hE0) begin
            ext_pend <= 1'b1;
        end else if (deliver) begin
            scan_ext <= ext_pend;
            ext_pend <= 1'b0;
        end
    end
`else
    assign scan_ext = 1'b0;
`endif
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_match
        assign match[k] = KEY_CODES[8*k +: 8] == scan_code;
    end
    // Press pulses only on released-to-held, so typematic repeats stay silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_held  <= '0;
            key_press <= '0;
        end else begin
            key_press <= (scan_valid && !scan_break) ? match & ~key_held : '0;
            if (scan_valid)
                key_held <= scan_break ? key_held & ~match : key_held | match;
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed frames against ps2_key_decoder with hand-computed expectations.
module tb_ps2_key_decoder;
    logic       clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [3:0] key_held, key_press;
    logic [7:0] scan_code;
    logic       scan_valid, scan_break, scan_ext, frame_err;
    int         tests = 0, fails = 0;
    int         sv_cnt = 0, err_cnt = 0;
    int         press_cnt [4] = '{0, 0, 0, 0};
    logic [7:0] codes [64];
    logic       brks [64];
    logic       exts [64];

    always #5 clk = ~clk;

    ps2_key_decoder #(.TIMEOUT_CYCLES(200)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_held(key_held), .key_press(key_press), .scan_code(scan_code),
        .scan_valid(scan_valid), .scan_break(scan_break), .scan_ext(scan_ext),
        .frame_err(frame_err)
    );

    // Counting high cycles makes any pulse wider than one cycle show up as an extra event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (scan_valid) begin
                codes[sv_cnt[5:0]] <= scan_code;
                brks[sv_cnt[5:0]]  <= scan_break;
                exts[sv_cnt[5:0]]  <= scan_ext;
                sv_cnt <= sv_cnt + 1;
            end
            if (frame_err) err_cnt <= err_cnt + 1;
            for (int i = 0; i < 4; i++)
                if (key_press[i]) press_cnt[i] <= press_cnt[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame bit 0 is the start bit; parity makes the 9-bit set odd unless bad_par flips it.
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int n);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < n; i++) begin
            ps2_data = fr[i];
            tick(5);
            ps2_clk = 1'b0;
            tick(10);
            ps2_clk = 1'b1;
            tick(5);
        end
        ps2_data = 1'b1;
        tick(20);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
    endtask

    initial begin
        tick(3);
        check("rst_outputs", {key_held, key_press, scan_code, scan_valid, scan_break, scan_ext, frame_err}, 0);
        rst_n = 1'b1;
        tick(5);
        check("idle_outputs", {key_held, key_press, scan_code, scan_valid, scan_break, scan_ext, frame_err}, 0);

        send(8'h1D);
        check("w_make_valid", sv_cnt, 1);
        check("w_make_code", codes[0], 8'h1D);
        check("w_make_brk", brks[0], 0);
        check("w_make_held", key_held, 4'b0001);
        check("w_make_press", press_cnt[0], 1);

        send(8'h1D);
        send(8'hF0);
        send(8'h1D);
        check("typematic_valid", sv_cnt, 3);
        check("typematic_press", press_cnt[0], 1);
        check("w_break_held", key_held, 4'b0000);
        check("w_break_code", codes[2], 8'h1D);
        check("w_break_flag", brks[2], 1);

        send_bits(8'h1C, 1'b1, 11);
        check("par_err", err_cnt, 1);
        check("par_no_valid", sv_cnt, 3);
        check("par_held", key_held, 4'b0000);
        send(8'h1C);
        check("a_make_held", key_held, 4'b0010);
        check("a_make_press", press_cnt[1], 1);

        send_bits(8'h00, 1'b0, 5);
        tick(300);
        check("tmo_err", err_cnt, 2);
        check("tmo_no_valid", sv_cnt, 4);
        send(8'h23);
        check("d_after_tmo_held", key_held, 4'b1010);
        check("d_after_tmo_code", codes[4], 8'h23);

        send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h23);
        send(8'h1D); send(8'h1B);
        check("pre_rst_held", key_held, 4'b0101);
        check("pre_rst_valid", sv_cnt, 9);
        check("pre_rst_press2", press_cnt[2], 1);

        send_bits(8'h1D, 1'b0, 3);
        rst_n = 1'b0;
        tick(2);
        check("mid_rst_outputs", {key_held, key_press, scan_code, scan_valid, scan_break, scan_ext, frame_err}, 0);
        rst_n = 1'b1;
        tick(5);
        send(8'h1B);
        check("post_rst_held", key_held, 4'b0100);
        check("post_rst_code", codes[9], 8'h1B);
        check("post_rst_press", press_cnt[2], 2);
        check("post_rst_err", err_cnt, 2);

        send(8'hE0); send(8'hF0); send(8'h75);
`ifdef PS2_EXT_EN
        check("ext_valid", sv_cnt, 11);
        check("ext_code", codes[10], 8'h75);
        check("ext_flag", exts[10], 1);
        check("ext_brk", brks[10], 1);
`else
        check("noext_valid", sv_cnt, 12);
        check("noext_e0_code", codes[10], 8'hE0);
        check("noext_e0_brk", brks[10], 0);
        check("noext_code", codes[11], 8'h75);
        check("noext_brk", brks[11], 1);
        check("noext_flag", exts[11], 0);
`endif
        check("ext_held", key_held, 4'b0100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 keyboard receiver and key-state decoder for the game input path. It oversamples the PS/2 clock and data lines in the system clock domain, validates each 11-bit frame (start, parity, stop), and strips the F0 break and E0 extended prefixes. It matches the resulting codes against a configurable key table and drives per-key held levels and press pulses for the game logic.

## Interface
- NUM_KEYS, 4: number of tracked keys (1..16).
- KEY_CODES, {8'h23,8'h1B,8'h1C,8'h1D}: flattened table, 8 bits per key; key i = KEY_CODES[8*i+7:8*i] (defaults: 0=W, 1=A, 2=S, 3=D).
- FILTER_LEN, 4: cycles ps2_clk must be stable before an edge is accepted (2..15).
- TIMEOUT_CYCLES, 50000: idle cycles inside a frame before the frame is aborted.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous).
- ps2_data  in  1  raw PS/2 data pin (asynchronous).
- key_held  out  NUM_KEYS  level: key i currently held.
- key_press  out  NUM_KEYS  one-cycle pulse on the released-to-held transition of key i.
- scan_code  out  8  last valid data byte, prefixes excluded.
- scan_valid  out  1  one-cycle pulse: scan_code/scan_break/scan_ext updated.
- scan_break  out  1  qualifies scan_code as a release.
- scan_ext  out  1  qualifies scan_code as E0-prefixed.
- frame_err  out  1  one-cycle pulse on a bad start, parity or stop bit, or on a timeout.

## Operation
- Input stage: both pins pass through 2-flop synchronisers. The synchronised ps2_clk feeds a stability filter: the filtered level changes only after FILTER_LEN consecutive equal samples. A falling edge of the filtered clock is the sample strobe; ps2_data is sampled on that strobe.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: a strobe with data=0 goes to DATA with the bit count at 0. A strobe with data=1 pulses frame_err and stays in IDLE.
  - DATA: 8 strobes shift in bits LSB first, then the FSM goes to PARITY.
  - PARITY: the sampled bit must make the 9-bit set odd; the result is recorded and the FSM goes to STOP.
  - STOP: the sampled bit must be 1. If both parity and stop are good, the byte goes to the decoder; otherwise frame_err pulses. Either way the FSM returns to IDLE.
- Timeout: in any state other than IDLE, a counter resets on every strobe. Reaching TIMEOUT_CYCLES forces IDLE, pulses frame_err and clears the prefix flags.
- Prefix decoder:
  - Byte F0: set brk_pend; no scan_valid.
  - Byte E0 (see Configuration): set ext_pend; no scan_valid.
  - Any other byte: scan_code=byte, scan_break=brk_pend, scan_ext=ext_pend, scan_valid pulses, then both flags clear.
- Key table: on scan_valid, every i whose KEY_CODES entry equals scan_code is updated. Break clears key_held[i]. Make sets key_held[i] and pulses key_press[i] only if key_held[i] was 0, so typematic repeats give no pulse. Duplicate table entries update all matching keys.
- A frame_err does not alter key_held.

## Timing
- Reset values: key_held=0, key_press=0, scan_code=8'h00, scan_valid=0, scan_break=0, scan_ext=0, frame_err=0. FSM in IDLE, flags and counters cleared.
- Strobe latency: 2 sync cycles + FILTER_LEN cycles after the pin's falling edge.
- scan_valid and frame_err: asserted on the cycle after the stop-bit strobe.
- key_held/key_press: update on the cycle after scan_valid.
- Reset mid-frame: all state returns to its reset value immediately. The partial frame is discarded, and the next frame with a valid start bit is received normally.
- Pulses are exactly 1 cycle wide. Strobes closer together than FILTER_LEN+1 cycles are not supported.

## Configuration
- PS2_EXT_EN defined: E0 is treated as a prefix, and scan_ext reflects it. A key table entry matches regardless of scan_ext.
- PS2_EXT_EN undefined: E0 is delivered as an ordinary byte (scan_valid, scan_code=8'hE0, which matches no default key). ext_pend logic is removed and scan_ext is tied to 0.

## Test plan
- Frame 1D (W make) -> scan_valid, scan_code=1D, scan_break=0; key_held=4'b0001, key_press=4'b0001 for 1 cycle.
- 1D, 1D, F0 1D -> exactly one key_press[0] pulse; key_held[0]=0 after the F0 1D break; scan_break=1 on the final scan_valid.
- 1C frame with parity flipped -> frame_err pulse, no scan_valid, key_held unchanged; then a good 1C frame -> key_held[1]=1.
- Send 5 bits, then idle TIMEOUT_CYCLES -> frame_err pulse, FSM in IDLE; the next full 23 frame is received (key_held[3]=1).
- rst_n low mid-frame while key_held=4'b0101 -> all outputs 0; a subsequent 1B frame -> key_held=4'b0100.
- With PS2_EXT_EN: E0 F0 75 -> a single scan_valid with scan_code=75, scan_ext=1, scan_break=1. Without it: two scan_valid pulses, E0 then 75 with scan_break=1.
